// File: rtl/interp_fir.sv
// Serial-MAC FIR for the interpolation path: one tap per cycle over a NTAPS-deep
// delay line, with rounded and saturated Q1.15 output and a sticky overrun flag.
module interp_fir #(
    parameter int NTAPS = 16,
    parameter int ACC_W = 36
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] audio_in,
    input  logic               valid_in,
    output logic               ready,
    input  logic               coef_we,
    input  logic [3:0]         coef_addr,
    input  logic signed [15:0] coef_data,
    input  logic               clr_ovr,
    output logic signed [15:0] audio_out,
    output logic               valid_out,
    output logic               overrun,
    output logic [1:0]         dbg_state
);

    localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NTAPS - 1);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-32768);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(16384);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [15:0]      x_q [NTAPS];
    logic signed [15:0]      c_q [NTAPS];
    logic signed [ACC_W-1:0] acc_q;
    logic [KW-1:0]           k_q;
    logic                    out_pend_q;

    logic                    accept;
    logic                    drop;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] shifted;
    logic signed [15:0]      sat;

    // Handshake: a sample is taken on any edge where valid_in=1 and ready=1;
    // valid_in while ready=0 is dropped and flagged, never stalled.
    assign ready     = (state_q == IDLE);
    assign accept    = valid_in && ready;
    assign drop      = valid_in && !ready;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_in) state_d = MAC;
            MAC:     if (k_q == K_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    assign prod = x_q[k_q] * c_q[k_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++) begin
                x_q[i] <= '0;
                c_q[i] <= (i == 0) ? 16'sh7FFF : 16'sh0000;
            end
            acc_q <= '0;
            k_q   <= '0;
        end else begin
            if (accept) begin
                x_q[0] <= audio_in;
                for (int i = 1; i < NTAPS; i++) x_q[i] <= x_q[i-1];
                acc_q <= '0;
                k_q   <= '0;
            end else if (state_q == MAC) begin
                acc_q <= acc_q + {{(ACC_W-32){prod[31]}}, prod};
                k_q   <= k_q + 1'b1;
            end
            // Writes land only while idle so a running sum never mixes old and new taps.
            if (coef_we && ready && (int'(coef_addr) < NTAPS)) c_q[coef_addr] <= coef_data;
        end
    end

    assign rnd     = acc_q + HALF;
    assign shifted = rnd >>> 15;
    always_comb begin
        sat = shifted[15:0];
        if (shifted > MAX_V)      sat = 16'sh7FFF;
        else if (shifted < MIN_V) sat = 16'sh8000;
    end

    // Result leaves one edge after DONE; acc is stable until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pend_q <= 1'b0;
            audio_out  <= '0;
            valid_out  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            out_pend_q <= (state_q == DONE);
            valid_out  <= out_pend_q;
            if (out_pend_q) audio_out <= sat;
            if (drop)         overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end

endmodule

// File: doc/interp_fir.md
INTERP_FIR -- requirements
Module: interp_fir

Interface
REQ-001 Parameter NTAPS, default 16, number of filter taps and delay-line depth.
REQ-002 Parameter ACC_W, default 36, accumulator width in bits (signed).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 audio_in  input  16  signed sample from the zero-insertion upsampler, two's complement.
REQ-006 valid_in  input  1  audio_in qualifier, single-cycle strobe.
REQ-007 ready  output  1  high when a valid_in is accepted on this edge (state IDLE).
REQ-008 coef_we  input  1  coefficient write enable.
REQ-009 coef_addr  input  4  tap index for the write.
REQ-010 coef_data  input  16  signed Q1.15 coefficient.
REQ-011 clr_ovr  input  1  clears the overrun flag.
REQ-012 audio_out  output  16  filtered signed sample, registered.
REQ-013 valid_out  output  1  one-cycle strobe qualifying audio_out.
REQ-014 overrun  output  1  sticky flag: a valid_in was dropped.

Function
REQ-015 Shall implement a serial-MAC FIR: y = sum over k=0..NTAPS-1 of x[k]*c[k]. x[0] is the newest sample.
REQ-016 FSM states shall be IDLE, MAC and DONE. ready shall be high only in IDLE.
REQ-017 In IDLE, valid_in=1 shall shift audio_in into x[0] and shift x[k] into x[k+1], discarding the oldest sample. It shall also clear the accumulator and tap counter to 0 and move to MAC.
REQ-018 In MAC, each cycle shall add x[k]*c[k] (32-bit signed product, sign-extended to ACC_W) to the accumulator and increment k. After the edge that processes k=NTAPS-1 (exactly NTAPS cycles), the FSM shall move to DONE.
REQ-019 In DONE, the result shall be formed as (acc + 2^14) arithmetically shifted right by 15. It shall saturate to [-32768, 32767], be registered into audio_out with valid_out=1 for one cycle, and the FSM shall return to IDLE.
REQ-020 Latency: valid_out shall be high in the cycle that begins NTAPS+2 edges after the accepting edge. Minimum input spacing is NTAPS+2 cycles.
REQ-021 audio_out shall hold its last value between strobes; valid_out shall be 0 otherwise.
REQ-022 valid_in while state is not IDLE shall drop the sample, leave the delay line unchanged and set overrun on the same edge.
REQ-023 clr_ovr=1 shall clear overrun. If a drop occurs on the same edge, set shall win.
REQ-024 coef_we shall write c[coef_addr]=coef_data only in IDLE. Writes in MAC or DONE shall be ignored.
REQ-025 coef_we and valid_in on the same IDLE edge: both shall take effect, and the new coefficient shall be used in the MAC.
REQ-026 The accumulator shall not wrap for any input/coefficient combination at NTAPS=16, ACC_W=36.

Reset
REQ-027 rst_n low shall asynchronously force: FSM to IDLE, delay line all 0, accumulator 0, k=0, audio_out=0, valid_out=0, overrun=0, ready=1 after reset.
REQ-028 Reset shall load c[0]=16'h7FFF and c[1..NTAPS-1]=0, giving pass-through.
REQ-029 Reset asserted mid-MAC shall abort the computation. No valid_out shall follow after release.

Verification
REQ-030 Pass-through: after reset, audio_in=1000 with valid_in -> audio_out=1000, valid_out on the 18th edge after acceptance; audio_in=-1000 -> -1000.
REQ-031 Impulse: write c[k]=k*256, then feed 16'h4000 followed by 15 samples of 0 -> outputs 0,128,256,...,1920 in order.
REQ-032 Saturation: all c[k]=16'h7FFF, feed 16 samples of 32767 -> final audio_out=32767. Repeating with -32768 samples -> -32768.
REQ-033 Overrun: valid_in 5 cycles after an accept -> sample dropped, overrun=1, that output unchanged. clr_ovr -> overrun=0. clr_ovr coinciding with a new drop -> overrun stays 1.
REQ-034 Coefficient write while busy: coef_we during MAC -> ignored, the next output uses the old coefficient.
REQ-035 Reset mid-MAC: assert rst_n low at MAC cycle 7 -> all outputs reset, no valid_out. The next input, 500, gives output 500.
